// File: rtl/conv_pkg.sv
// Shared definitions for the two-layer convolution sequencer and its users.
package conv_pkg;

  // Sequencer states, in run order.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR1   = 3'd1,
    ST_FEED1  = 3'd2,
    ST_DRAIN1 = 3'd3,
    ST_CLR2   = 3'd4,
    ST_FEED2  = 3'd5,
    ST_DRAIN2 = 3'd6,
    ST_FIN    = 3'd7
  } sched_state_t;

  // Number of valid convolution outputs produced per layer.
  function automatic int nout(input int img_w, input int img_h, input int k);
    return (img_w - k + 1) * (img_h - k + 1);
  endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// Raster-order address generator: row/col counters with wrap, a running
// row*IMG_W+col accumulator (no multiplier) and a last-address flag.
module raster_addr_gen #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  assign last = (row == ROW_LAST) && (col == COL_LAST);

  // Advance col/row and the address accumulator; everything wraps to 0 after the last pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (clr) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (step) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
      addr <= last ? '0 : addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/conv_layer_sched.sv
// Two-layer convolution sequencer: clears the conv line buffers, streams
// raster read addresses for each layer, counts the layer's output strobes
// into result-memory write addresses and flags surplus or missing outputs.
module conv_layer_sched
  import conv_pkg::*;
#(
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int K         = 3,
  parameter int ADDR_W    = 8,
  parameter int DRAIN_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              layer_sel,
  output logic              conv_clear,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pix_valid,
  input  logic              out_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int NOUT  = nout(IMG_W, IMG_H, K);
  localparam int CNT_W = $clog2(NOUT + 1);
  localparam int DRN_W = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] NOUT_C   = CNT_W'(NOUT);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_MAX - 1);

  sched_state_t     state, state_nxt;
  logic [CNT_W-1:0] out_cnt;
  logic [DRN_W-1:0] drain_cnt;
  logic             rd_last;
  logic             capture_act;
  logic             cnt_full;
  logic             in_drain;
  logic             drain_tmo;
  logic             excess;
  logic             cnt_clr;

  raster_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_rd_gen (
    .clk (clk),
    .rst (rst),
    .clr (conv_clear),
    .step(rd_en),
    .addr(rd_addr),
    .last(rd_last)
  );

  // Output capture: results are accepted in every state except IDLE/FIN and
  // written straight away at the running count.
  always_comb begin
    capture_act = (state != ST_IDLE) && (state != ST_FIN);
    cnt_full    = (out_cnt == NOUT_C);
    in_drain    = (state == ST_DRAIN1) || (state == ST_DRAIN2);
    drain_tmo   = (drain_cnt == DRN_LAST) && !cnt_full;
    wr_en       = capture_act && out_valid && !cnt_full;
    excess      = capture_act && out_valid && cnt_full;
    wr_addr     = ADDR_W'(out_cnt);
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    layer_sel  = 1'b0;
    conv_clear = 1'b0;
    rd_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CLR1;
      end
      ST_CLR1: begin
        busy       = 1'b1;
        conv_clear = 1'b1;
        state_nxt  = ST_FEED1;
      end
      ST_FEED1: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (rd_last) state_nxt = ST_DRAIN1;
      end
      ST_DRAIN1: begin
        busy = 1'b1;
        if (cnt_full || drain_tmo) state_nxt = ST_CLR2;
      end
      ST_CLR2: begin
        busy       = 1'b1;
        layer_sel  = 1'b1;
        conv_clear = 1'b1;
        state_nxt  = ST_FEED2;
      end
      ST_FEED2: begin
        busy      = 1'b1;
        layer_sel = 1'b1;
        rd_en     = 1'b1;
        if (rd_last) state_nxt = ST_DRAIN2;
      end
      ST_DRAIN2: begin
        busy      = 1'b1;
        layer_sel = 1'b1;
        if (cnt_full || drain_tmo) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        done      = 1'b1;
        layer_sel = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cnt_clr = (state_nxt == ST_CLR1) || (state_nxt == ST_CLR2);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Output counter: cleared on entry to each CLR so a write in the cycle that
  // leaves DRAIN1 still belongs to layer 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         out_cnt <= '0;
    else if (cnt_clr) out_cnt <= '0;
    else if (wr_en)   out_cnt <= out_cnt + CNT_W'(1);
  end

  // Drain timer: counts cycles spent waiting for the last outputs of a layer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          drain_cnt <= '0;
    else if (in_drain) drain_cnt <= drain_cnt + DRN_W'(1);
    else               drain_cnt <= '0;
  end

  // Sticky error: surplus output or drain timeout; cleared by an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                err <= 1'b0;
    else if ((state == ST_IDLE) && start)    err <= 1'b0;
    else if (excess || (in_drain && drain_tmo)) err <= 1'b1;
  end

  // Pixel-valid trails the read strobe by the memory's one-cycle latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pix_valid <= 1'b0;
    else      pix_valid <= rd_en;
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Scoreboard bench for conv_layer_sched: stimulus tasks push expected reads,
// writes, clears and done pulses; a negedge monitor pops and compares them.
module tb_conv_layer_sched;

  localparam int IMG_W     = 8;
  localparam int IMG_H     = 8;
  localparam int K         = 3;
  localparam int ADDR_W    = 8;
  localparam int DRAIN_MAX = 64;
  localparam int NPIX      = 64;
  localparam int NOUT      = 36;

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic              layer_sel;
  logic              conv_clear;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              pix_valid;
  logic              out_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  conv_layer_sched #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .K        (K),
    .ADDR_W   (ADDR_W),
    .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .layer_sel (layer_sel),
    .conv_clear(conv_clear),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .pix_valid (pix_valid),
    .out_valid (out_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] addr;
    logic       lsel;
  } acc_t;

  acc_t rd_q[$];
  acc_t wr_q[$];
  bit   clr_q[$];
  bit   done_q[$];

  int checks   = 0;
  int failures = 0;
  int last_rd_cyc = 0;
  bit prev_rd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: compares every DUT event against the queued expectations.
  always @(negedge clk) begin
    acc_t e;
    bit   b;
    if (!rst) begin
      prev_rd = 1'b0;
    end else begin
      check("pix_valid_lag", {31'd0, pix_valid}, {31'd0, prev_rd});
      prev_rd = rd_en;
      if (rd_en) begin
        last_rd_cyc = cyc;
        if (rd_q.size() == 0) fail_now("rd_unexpected");
        else begin
          e = rd_q.pop_front();
          check("rd_addr", {24'd0, rd_addr}, {24'd0, e.addr});
          check("rd_layer", {31'd0, layer_sel}, {31'd0, e.lsel});
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) fail_now("wr_unexpected");
        else begin
          e = wr_q.pop_front();
          check("wr_addr", {24'd0, wr_addr}, {24'd0, e.addr});
          check("wr_layer", {31'd0, layer_sel}, {31'd0, e.lsel});
        end
      end
      if (conv_clear) begin
        if (clr_q.size() == 0) fail_now("clr_unexpected");
        else begin
          b = clr_q.pop_front();
          check("clr_layer", {31'd0, layer_sel}, {31'd0, b});
        end
      end
      if (done) begin
        if (done_q.size() == 0) fail_now("done_unexpected");
        else begin
          b = done_q.pop_front();
          check("done_err", {31'd0, err}, {31'd0, b});
          check("done_busy", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_reads(input bit lsel, input int n);
    for (int i = 0; i < n; i++) rd_q.push_back('{addr: 8'(i), lsel: lsel});
  endtask

  task automatic push_run(input bit err_exp);
    push_reads(1'b0, NPIX);
    push_reads(1'b1, NPIX);
    clr_q.push_back(1'b0);
    clr_q.push_back(1'b1);
    done_q.push_back(err_exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_layer_sel"}, {31'd0, layer_sel}, 32'd0);
    check({tag, "_conv_clear"}, {31'd0, conv_clear}, 32'd0);
    check({tag, "_rd_en"}, {31'd0, rd_en}, 32'd0);
    check({tag, "_rd_addr"}, {24'd0, rd_addr}, 32'd0);
    check({tag, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
    check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    check({tag, "_wr_addr"}, {24'd0, wr_addr}, 32'd0);
  endtask

  // Pulse start for one cycle from IDLE and check CLR1 / first read timing.
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clr1_conv_clear", {31'd0, conv_clear}, 32'd1);
    check("clr1_busy", {31'd0, busy}, 32'd1);
    check("clr1_err_cleared", {31'd0, err}, 32'd0);
    tick();
    check("first_rd_en", {31'd0, rd_en}, 32'd1);
    check("first_rd_addr", {24'd0, rd_addr}, 32'd0);
  endtask

  // Wait for the first read of a layer, then return n results from FEED cycle 20.
  task automatic drive_layer(input int n, input bit lsel, input bit poke);
    bit ok = 1'b0;
    for (int t = 0; t < 600; t++) begin
      if (rd_en && (rd_addr == 8'd0) && (layer_sel == lsel)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      fail_now("feed_timeout");
      return;
    end
    repeat (10) tick();
    if (poke) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
    end else begin
      repeat (10) tick();
    end
    for (int i = 0; i < n; i++) begin
      out_valid = 1'b1;
      if (i < NOUT) wr_q.push_back('{addr: 8'(i), lsel: lsel});
      tick();
    end
    out_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail_now("done_timeout");
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int d_cyc;
    bit ok;
    rst       = 1'b0;
    start     = 1'b0;
    out_valid = 1'b0;
    repeat (3) tick();
    check_reset_vals("por");
    rst = 1'b1;
    tick();

    // out_valid while idle is ignored
    out_valid = 1'b1;
    #1;
    check("idle_wr_en", {31'd0, wr_en}, 32'd0);
    tick();
    out_valid = 1'b0;
    check("idle_err", {31'd0, err}, 32'd0);
    tick();

    // Nominal run
    push_run(1'b0);
    start_run();
    drive_layer(NOUT, 1'b0, 1'b0);
    drive_layer(NOUT, 1'b1, 1'b0);
    wait_done();
    check("nom_done_err", {31'd0, err}, 32'd0);
    tick();
    check("nom_after_busy", {31'd0, busy}, 32'd0);
    check("nom_after_done", {31'd0, done}, 32'd0);
    repeat (3) tick();

    // Reset in the middle of FEED2 at rd_addr 30
    push_reads(1'b0, NPIX);
    push_reads(1'b1, 30);
    clr_q.push_back(1'b0);
    clr_q.push_back(1'b1);
    start_run();
    drive_layer(NOUT, 1'b0, 1'b0);
    drive_layer(5, 1'b1, 1'b0);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (rd_en && layer_sel && (rd_addr == 8'd30)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail_now("rd30_timeout");
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick();
    tick();
    rst = 1'b1;
    tick();
    push_run(1'b0);
    start_run();
    drive_layer(NOUT, 1'b0, 1'b0);
    drive_layer(NOUT, 1'b1, 1'b0);
    wait_done();
    repeat (3) tick();

    // Excess output in layer 1
    push_run(1'b1);
    start_run();
    drive_layer(NOUT + 1, 1'b0, 1'b0);
    check("excess_err_set", {31'd0, err}, 32'd1);
    drive_layer(NOUT, 1'b1, 1'b0);
    wait_done();
    check("excess_err_at_done", {31'd0, err}, 32'd1);
    repeat (3) tick();
    check("excess_err_sticky", {31'd0, err}, 32'd1);

    // Missing output in layer 2, with start pokes during FEED1 and DRAIN2
    push_run(1'b1);
    start_run();
    drive_layer(NOUT, 1'b0, 1'b1);
    drive_layer(NOUT - 1, 1'b1, 1'b0);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (!rd_en) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail_now("feed2_end_timeout");
    repeat (10) tick();
    check("drain_err_pending", {31'd0, err}, 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    check("drain_timeout_len", 32'(cyc - last_rd_cyc), 32'd65);
    tick();
    check("no_restart_busy", {31'd0, busy}, 32'd0);
    tick();
    check("no_restart_clear", {31'd0, conv_clear}, 32'd0);
    repeat (2) tick();

    // Back-to-back runs with start held high
    push_run(1'b0);
    push_run(1'b0);
    start = 1'b1;
    drive_layer(NOUT, 1'b0, 1'b0);
    drive_layer(NOUT, 1'b1, 1'b0);
    wait_done();
    d_cyc = cyc;
    tick();
    check("b2b_idle_clear", {31'd0, conv_clear}, 32'd0);
    tick();
    check("b2b_clr1_clear", {31'd0, conv_clear}, 32'd1);
    check("b2b_clr1_layer", {31'd0, layer_sel}, 32'd0);
    check("b2b_clr1_gap", 32'(cyc - d_cyc), 32'd2);
    start = 1'b0;
    drive_layer(NOUT, 1'b0, 1'b0);
    drive_layer(NOUT, 1'b1, 1'b0);
    wait_done();
    repeat (4) tick();

    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("clr_q_empty", 32'(clr_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
